// File: rtl/fft_frame_sched.sv
// Frame scheduler: one FFT analysis frame per trigger (core reset, feed, drain, RAM write, detect enable).
// Latency: trigger in IDLE -> first s_tvalid after 1 + RST_CYC cycles; detect_en one cycle after write completion.
// Backpressure: s_tready low holds the feed beat count; the wait states are bounded by a TIMEOUT_CYC watchdog.
//
// Ports: clk/rst (sync, active high); start_pulse/auto_en trigger inputs; fft_aresetn + s_tvalid/s_tlast/s_tready
// drive the FFT input; m_tvalid/m_tlast observe the FFT output; wr_done/detect_en/detect_done handshake with the
// RAM writer and modulation detector; busy/frame_cnt/overrun/timeout_err status, clr_flags clears the sticky flags.

module fft_frame_sched #(
    parameter int FFT_LEN     = 256,
    parameter int CNT_W       = 8,
    parameter int PERIOD_CYC  = 25000000,
    parameter int RST_CYC     = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_pulse,
    input  logic        auto_en,
    output logic        fft_aresetn,
    output logic        s_tvalid,
    output logic        s_tlast,
    input  logic        s_tready,
    input  logic        m_tvalid,
    input  logic        m_tlast,
    input  logic        wr_done,
    output logic        detect_en,
    input  logic        detect_done,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        overrun,
    output logic        timeout_err,
    input  logic        clr_flags
);

    localparam int PER_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int RC_W  = $clog2(RST_CYC + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(FFT_LEN - 1);
    localparam logic [RC_W-1:0]  RST_LAST  = RC_W'(RST_CYC - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_FEED,
        S_DRAIN,
        S_WAIT_WR,
        S_DETECT
    } state_t;

    state_t             state_q, state_d;
    logic [PER_W-1:0]   period_cnt_q, period_cnt_d;
    logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic               wr_seen_q, wr_seen_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               overrun_q, overrun_d;
    logic               timeout_err_q, timeout_err_d;
    logic               fft_aresetn_q, fft_aresetn_d;

    logic               wrap;
    logic               trig;
    logic               progress;

    always_comb begin
        wrap          = (period_cnt_q == PER_LAST);
        // A coincident start_pulse and wrap collapse into one trigger.
        trig          = (wrap && auto_en) || start_pulse;
        period_cnt_d  = wrap ? '0 : period_cnt_q + 1'b1;

        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        wd_cnt_d      = wd_cnt_q;
        wr_seen_d     = wr_seen_q;
        frame_cnt_d   = frame_cnt_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;
        progress      = 1'b0;

        // Clear first so that a same-cycle set event below wins.
        if (clr_flags) begin
            overrun_d     = 1'b0;
            timeout_err_d = 1'b0;
        end

        // Triggers while a frame is in flight are dropped, never queued.
        if (trig && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d   = S_RST;
                    rst_cnt_d = '0;
                end
            end
            S_RST: begin
                in_cnt_d  = '0;
                out_cnt_d = '0;
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_FEED;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_FEED: begin
                if (s_tready) begin
                    if (in_cnt_q == BEAT_LAST) begin
                        state_d   = S_DRAIN;
                        wd_cnt_d  = '0;
                        wr_seen_d = 1'b0;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // The RAM writer may finish before the FFT's last beat is seen here.
                if (wr_done) begin
                    wr_seen_d = 1'b1;
                end
                if (m_tvalid) begin
                    // An early m_tlast just ends the drain; it is not flagged.
                    if (m_tlast || (out_cnt_q == BEAT_LAST)) begin
                        progress = 1'b1;
                        state_d  = S_WAIT_WR;
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT_WR: begin
                if (wr_done || wr_seen_q) begin
                    progress  = 1'b1;
                    wr_seen_d = 1'b0;
                    state_d   = S_DETECT;
                end
            end
            S_DETECT: begin
                if (detect_done) begin
                    progress    = 1'b1;
                    state_d     = S_IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog over the externally paced states. Forward progress restarts it
        // for the next state; otherwise the TIMEOUT_CYC-th idle cycle aborts the frame.
        if (state_q inside {S_DRAIN, S_WAIT_WR, S_DETECT}) begin
            if (progress) begin
                wd_cnt_d = '0;
            end else if (wd_cnt_q == WD_LAST) begin
                state_d       = S_IDLE;
                timeout_err_d = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end

        fft_aresetn_d = (state_d != S_RST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            period_cnt_q  <= '0;
            rst_cnt_q     <= '0;
            in_cnt_q      <= '0;
            out_cnt_q     <= '0;
            wd_cnt_q      <= '0;
            wr_seen_q     <= 1'b0;
            frame_cnt_q   <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            fft_aresetn_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            rst_cnt_q     <= rst_cnt_d;
            in_cnt_q      <= in_cnt_d;
            out_cnt_q     <= out_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            wr_seen_q     <= wr_seen_d;
            frame_cnt_q   <= frame_cnt_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            fft_aresetn_q <= fft_aresetn_d;
        end
    end

    assign fft_aresetn = fft_aresetn_q;
    assign s_tvalid    = (state_q == S_FEED);
    assign s_tlast     = (state_q == S_FEED) && (in_cnt_q == BEAT_LAST);
    // The watchdog count restarts on DETECT entry, so zero marks its first cycle.
    assign detect_en   = (state_q == S_DETECT) && (wd_cnt_q == '0);
    assign busy        = (state_q != S_IDLE);
    assign frame_cnt   = frame_cnt_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: directed frames with fixed expectations, then randomized traffic
// compared cycle by cycle against a phase/duration reference model.
// Inputs change #1 after the rising edge; outputs are compared on the falling edge.

module tb_fft_frame_sched;

    localparam int FFT_LEN     = 8;
    localparam int PERIOD_CYC  = 100;
    localparam int RST_CYC     = 2;
    localparam int TIMEOUT_CYC = 50;

    localparam int P_IDLE  = 0;
    localparam int P_RST   = 1;
    localparam int P_FEED  = 2;
    localparam int P_DRAIN = 3;
    localparam int P_WAIT  = 4;
    localparam int P_DET   = 5;

    logic        clk = 1'b0;
    logic        rst, start_pulse, auto_en, s_tready, m_tvalid, m_tlast;
    logic        wr_done, detect_done, clr_flags;
    logic        fft_aresetn, s_tvalid, s_tlast, detect_en, busy, overrun, timeout_err;
    logic [15:0] frame_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: which phase the frame is in, how long it has been there,
    // and how many beats that phase has moved.
    int m_ph, m_n, m_beats, m_period, m_frames;
    bit m_ovr, m_to, m_wrseen, m_aresetn;

    fft_frame_sched #(
        .FFT_LEN(FFT_LEN), .CNT_W(3), .PERIOD_CYC(PERIOD_CYC),
        .RST_CYC(RST_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .auto_en(auto_en),
        .fft_aresetn(fft_aresetn), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tlast(m_tlast), .wr_done(wr_done), .detect_en(detect_en),
        .detect_done(detect_done), .busy(busy), .frame_cnt(frame_cnt), .overrun(overrun),
        .timeout_err(timeout_err), .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_step();
        bit wrap_m, trig_m;
        int ph0;
        if (rst) begin
            m_ph = P_IDLE; m_n = 0; m_beats = 0; m_period = 0; m_frames = 0;
            m_ovr = 0; m_to = 0; m_wrseen = 0; m_aresetn = 0;
            return;
        end
        wrap_m   = (m_period == PERIOD_CYC - 1);
        trig_m   = start_pulse || (wrap_m && auto_en);
        m_period = wrap_m ? 0 : m_period + 1;
        if (clr_flags) begin m_ovr = 0; m_to = 0; end
        if (trig_m && m_ph != P_IDLE) m_ovr = 1;
        ph0 = m_ph;
        case (m_ph)
            P_IDLE:  if (trig_m) m_ph = P_RST;
            P_RST:   if (m_n + 1 == RST_CYC) m_ph = P_FEED;
            P_FEED: begin
                if (s_tready) m_beats++;
                if (m_beats == FFT_LEN) begin m_ph = P_DRAIN; m_wrseen = 0; end
            end
            P_DRAIN: begin
                if (wr_done) m_wrseen = 1;
                if (m_tvalid) begin
                    m_beats++;
                    if (m_tlast || m_beats == FFT_LEN) m_ph = P_WAIT;
                end
            end
            P_WAIT:  if (wr_done || m_wrseen) begin m_wrseen = 0; m_ph = P_DET; end
            P_DET:   if (detect_done) begin m_frames = (m_frames + 1) & 16'hFFFF; m_ph = P_IDLE; end
            default: m_ph = P_IDLE;
        endcase
        if (m_ph != ph0) begin
            m_n = 0; m_beats = 0;
        end else begin
            m_n++;
            if ((m_ph == P_DRAIN || m_ph == P_WAIT || m_ph == P_DET) && m_n == TIMEOUT_CYC) begin
                m_to = 1; m_ph = P_IDLE; m_n = 0; m_beats = 0;
            end
        end
        m_aresetn = (m_ph != P_RST);
    endtask

    // One clock: compare the current cycle against the model, then advance both.
    task automatic tick();
        @(negedge clk);
        chk("fft_aresetn", 32'(fft_aresetn), 32'(m_aresetn));
        chk("s_tvalid",    32'(s_tvalid),    32'(m_ph == P_FEED));
        chk("s_tlast",     32'(s_tlast),     32'(m_ph == P_FEED && m_beats == FFT_LEN - 1));
        chk("detect_en",   32'(detect_en),   32'(m_ph == P_DET && m_n == 0));
        chk("busy",        32'(busy),        32'(m_ph != P_IDLE));
        chk("frame_cnt",   32'(frame_cnt),   32'(m_frames));
        chk("overrun",     32'(overrun),     32'(m_ovr));
        chk("timeout_err", 32'(timeout_err), 32'(m_to));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        start_pulse = 0; s_tready = 0; m_tvalid = 0; m_tlast = 0;
        wr_done = 0; detect_done = 0; clr_flags = 0;
    endtask

    // Segment knobs (percent): auto, rdy, mvalid, wr_done, detect_done, start, rst, clr.
    int seg_cfg [4][8] = '{
        '{1, 100, 100, 50, 50, 0, 0, 0},
        '{1,  70,  70, 30, 30, 3, 0, 2},
        '{0,  50,  50,  2,  5, 4, 0, 1},
        '{1,  60,  60, 20, 20, 3, 1, 2}
    };

    initial begin
        rst = 1; auto_en = 0;
        idle_inputs();
        repeat (2) begin @(posedge clk); model_step(); #1; end
        tick();
        rst = 0;
        // Cycle right after the last reset edge.
        chk("rst_aresetn", 32'(fft_aresetn), 32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_frames",  32'(frame_cnt),   32'd0);
        chk("rst_flags",   32'({overrun, timeout_err, s_tvalid, detect_en}), 32'd0);

        // Frame 1: manual start, s_tready always high.
        repeat (9) tick();
        start_pulse = 1; tick(); start_pulse = 0;
        s_tready = 1;
        for (int k = 1; k <= 11; k++) begin
            chk("f1_aresetn", 32'(fft_aresetn), 32'(k > RST_CYC));
            chk("f1_tvalid",  32'(s_tvalid),    32'(k > RST_CYC && k <= RST_CYC + FFT_LEN));
            chk("f1_tlast",   32'(s_tlast),     32'(k == RST_CYC + FFT_LEN));
            tick();
        end
        s_tready = 0;
        for (int b = 1; b <= FFT_LEN; b++) begin
            m_tvalid = 1; m_tlast = (b == FFT_LEN); tick();
        end
        m_tvalid = 0; m_tlast = 0;
        wr_done = 1; tick(); wr_done = 0;
        chk("f1_detect_en", 32'(detect_en), 32'd1);
        detect_done = 1; tick(); detect_done = 0;
        chk("f1_detect_en_off", 32'(detect_en), 32'd0);
        chk("f1_frames", 32'(frame_cnt), 32'd1);
        chk("f1_busy",   32'(busy),      32'd0);

        // Frame 2: s_tready toggles 1,0,... and wr_done is withheld -> watchdog.
        start_pulse = 1; tick(); start_pulse = 0;
        repeat (RST_CYC) tick();
        for (int k = 0; k < 2 * FFT_LEN; k++) begin
            s_tready = (k % 2 == 0); tick();
        end
        s_tready = 0;
        chk("f2_tvalid_off", 32'(s_tvalid), 32'd0);
        chk("f2_busy",       32'(busy),     32'd1);
        for (int b = 1; b <= FFT_LEN; b++) begin
            m_tvalid = 1; m_tlast = (b == FFT_LEN); tick();
        end
        m_tvalid = 0; m_tlast = 0;
        repeat (TIMEOUT_CYC - 1) tick();
        chk("f2_pre_to_busy", 32'(busy),        32'd1);
        chk("f2_pre_to_err",  32'(timeout_err), 32'd0);
        tick();
        chk("f2_to_err",    32'(timeout_err), 32'd1);
        chk("f2_to_busy",   32'(busy),        32'd0);
        chk("f2_to_frames", 32'(frame_cnt),   32'd1);
        clr_flags = 1; tick(); clr_flags = 0;
        chk("f2_clr", 32'(timeout_err), 32'd0);

        // Frame 3: reset in the middle of the feed, then a clean frame.
        start_pulse = 1; tick(); start_pulse = 0;
        s_tready = 1;
        repeat (RST_CYC + 3) tick();
        chk("f3_feeding", 32'(s_tvalid), 32'd1);
        rst = 1; tick(); rst = 0;
        chk("f3_rst_tvalid",  32'(s_tvalid),    32'd0);
        chk("f3_rst_busy",    32'(busy),        32'd0);
        chk("f3_rst_aresetn", 32'(fft_aresetn), 32'd0);
        tick();
        chk("f3_aresetn_up", 32'(fft_aresetn), 32'd1);
        start_pulse = 1; tick(); start_pulse = 0;
        repeat (RST_CYC + FFT_LEN) tick();
        m_tvalid = 1;
        repeat (FFT_LEN) tick();
        m_tvalid = 0; wr_done = 1; tick(); wr_done = 0;
        detect_done = 1; tick(); detect_done = 0;
        chk("f3_frames", 32'(frame_cnt), 32'd1);

        // Randomized traffic against the model.
        for (int s = 0; s < 4; s++) begin
            auto_en = seg_cfg[s][0][0];
            for (int c = 0; c < 1000; c++) begin
                s_tready    = ($urandom_range(99) < seg_cfg[s][1]);
                m_tvalid    = ($urandom_range(99) < seg_cfg[s][2]);
                m_tlast     = ($urandom_range(99) < 8);
                wr_done     = ($urandom_range(99) < seg_cfg[s][3]);
                detect_done = ($urandom_range(99) < seg_cfg[s][4]);
                start_pulse = ($urandom_range(99) < seg_cfg[s][5]);
                rst         = ($urandom_range(99) < seg_cfg[s][6]);
                clr_flags   = ($urandom_range(99) < seg_cfg[s][7]);
                tick();
            end
            if (s == 0) chk("auto_no_overrun", 32'(overrun), 32'd0);
        end
        idle_inputs(); rst = 0; auto_en = 0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_frame_sched.md
Name: fft_frame_sched

Overview:
- Replaces the key-driven FFT start with a periodic frame scheduler.
- Sequences one full analysis frame: FFT core reset, input feed of FFT_LEN samples, output drain, RAM write completion, then a one-shot modulation-detect enable.
- Sits in the clk_50m domain between the ADC sample stream and the FFT core, the modulus/RAM writer and the modulation detector.
- A frame starts every PERIOD_CYC cycles when auto mode is on, or on a manual start pulse.

Parameters:
FFT_LEN, 256, samples per frame and output beats expected
CNT_W, 8, log2(FFT_LEN); width of beat counters
PERIOD_CYC, 25000000, auto-trigger period (0.5 s at 50 MHz)
RST_CYC, 4, cycles fft_aresetn is held low per frame (at least 2)
TIMEOUT_CYC, 1000000, watchdog limit for each wait state

Ports:
clk  in  1  clk_50m, sole clock
rst  in  1  synchronous, active-high reset
start_pulse  in  1  debounced manual trigger, one-cycle pulse
auto_en  in  1  1 = periodic triggering enabled
fft_aresetn  out  1  FFT core reset, active low
s_tvalid  out  1  FFT input data valid
s_tlast  out  1  FFT input last beat
s_tready  in  1  FFT input ready
m_tvalid  in  1  FFT output valid
m_tlast  in  1  FFT output last
wr_done  in  1  RAM writer frame complete, pulse
detect_en  out  1  one-cycle enable to modulation detect
detect_done  in  1  modulation detect finished, pulse
busy  out  1  1 whenever state is not IDLE
frame_cnt  out  16  completed frames, wraps at 65535 to 0
overrun  out  1  sticky: trigger arrived while busy
timeout_err  out  1  sticky: watchdog fired
clr_flags  in  1  clears overrun and timeout_err

Behaviour:
- Reset values:
  - state = IDLE; fft_aresetn = 0 during rst, 1 in the first cycle after reset.
  - s_tvalid, s_tlast, detect_en, busy, overrun, timeout_err = 0; frame_cnt = 0.
  - period counter = 0; trigger pending = 0.
- Period counter:
  - Free-runs 0 to PERIOD_CYC-1, then wraps.
  - The wrap cycle with auto_en=1 raises trig.
  - trig = wrap OR start_pulse.
- IDLE, trig=1: latch pending, enter RST next cycle.
- Trig while busy: dropped, overrun set to 1. The current frame is unaffected.
- RST:
  - fft_aresetn = 0 for exactly RST_CYC cycles.
  - Beat counters cleared.
  - Then FEED.
- FEED:
  - s_tvalid = 1. A beat counts only when s_tvalid and s_tready are both 1.
  - s_tlast = 1 exactly while in_cnt = FFT_LEN-1.
  - After the handshake on the last beat: s_tvalid = 0 next cycle, enter DRAIN.
  - s_tready low: hold the count, keep s_tvalid = 1.
- DRAIN:
  - Count m_tvalid beats.
  - Exit to WAIT_WR on m_tvalid with m_tlast, or on m_tvalid with out_cnt = FFT_LEN-1, whichever comes first.
  - m_tlast at any other count still exits. This is not an error.
- WAIT_WR: wr_done pulse enters DETECT. A wr_done seen during DRAIN is also accepted: it is latched and consumed on entry.
- DETECT:
  - detect_en is high for exactly the first cycle of DETECT.
  - Wait for detect_done. On it, return to IDLE and increment frame_cnt in that same cycle.
  - detect_done coincident with detect_en counts.
- Watchdog:
  - Cleared on entry to DRAIN, WAIT_WR and DETECT; counts in those states.
  - On reaching TIMEOUT_CYC: timeout_err set, go to IDLE, frame_cnt not incremented.
  - fft_aresetn is reasserted by the next frame's RST.
- clr_flags and a set event in the same cycle: set wins.
- rst at any cycle, mid-frame included: all outputs return to reset values next edge, and no pending trigger survives.
- auto_en 1 to 0: no further periodic trigs; the current frame completes.
- start_pulse and wrap in the same cycle: a single trig.
- Latency from trig in IDLE to first s_tvalid: 1 + RST_CYC cycles.

Test Plan:
Run with FFT_LEN=8, PERIOD_CYC=100, RST_CYC=2, TIMEOUT_CYC=50.
- auto_en=0, start_pulse at cycle 10, s_tready=1 -> fft_aresetn low cycles 11-12; s_tvalid high cycles 13-20, s_tlast at cycle 20. Model returns 8 m_tvalid beats, wr_done, then detect_done -> detect_en one pulse, frame_cnt=1, busy=0.
- s_tready toggling 1,0,1,0 during FEED -> exactly 8 handshakes; s_tlast only on the 8th; s_tvalid never drops early.
- auto_en=1, model completes frames in under 100 cycles -> a frame starts every 100 cycles; frame_cnt=3 after 3 periods; overrun=0.
- start_pulse during DRAIN -> overrun=1; frame completes normally. clr_flags -> overrun=0.
- Withhold wr_done -> timeout_err=1 after 50 cycles in WAIT_WR; state IDLE; frame_cnt unchanged. Next start runs normally.
- rst asserted mid-FEED -> next cycle s_tvalid=0, busy=0, fft_aresetn=0; after release, a new start_pulse yields a full 8-beat frame.
